muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the execute stage; responder to the E-stage start pulse issued by the decode/execute pipeline register.
- Accepts one operation, computes in XLEN iterations, returns a registered result with a one-cycle done pulse.
- Drives the stall that freezes the upstream pipeline registers while it computes.
- Divide-by-zero and signed overflow complete early.

Parameters:
- XLEN, 32, operand/result width; also the iteration count.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- start, input, 1, launch request; sampled only in IDLE.
- kill, input, 1, abort (branch flush); synchronous.
- funct3, input, 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a, input, XLEN, rs1 operand.
- op_b, input, XLEN, rs2 operand.
- rd_i, input, 5, destination register tag.
- stall, output, 1, combinational freeze request to the pipeline.
- busy, output, 1, registered; high whenever state != IDLE.
- done, output, 1, registered; one-cycle result-valid pulse.
- result, output, XLEN, registered result; holds its value until the next done.
- rd_o, output, 5, registered tag; valid with done.

Behaviour:
- States:
  - IDLE: waits for start.
  - CALC: runs the iterations.
  - DONE: presents done and result.
- Reset: state IDLE; done 0; busy 0; result 0; rd_o 0; iteration counter 0; internal accumulators 0. stall is forced 0 while rst is high. rst mid-CALC aborts with no done.
- IDLE & start & normal op:
  - Capture operand magnitudes, sign flags, funct3 and rd_i.
  - Go to CALC with counter 0.
- IDLE & start & special case (funct3[2]=1 and either op_b=0, or signed overflow with op_a=0x80000000, op_b=all-ones, funct3 100/110):
  - Go directly to DONE with the result below.
- CALC: one iteration per cycle for XLEN cycles. Counter runs 0..XLEN-1; on XLEN-1 go to DONE and load result.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- start while busy: ignored; no state change.
- Latency: start high in IDLE at cycle 0.
  - Normal op: CALC cycles 1..XLEN; done at cycle XLEN+1 (cycle 33 for XLEN=32).
  - Special case: done at cycle 1.
- stall = (state==IDLE & start & ~rst) | (state==CALC). stall is low in DONE so the pipeline advances and captures result.
- kill: any state goes to IDLE next cycle; no done; result and rd_o unchanged. kill has priority over start and over DONE completion. rst has priority over kill.
- Multiply: unsigned shift-add on magnitudes into a 2*XLEN product.
  - Sign of the product: MUL/MULH = a_sign^b_sign; MULHSU = a_sign only; MULHU = unsigned.
  - Negate the 2*XLEN product if the sign is set.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide: restoring shift-subtract on magnitudes.
  - Quotient sign = a_sign^b_sign (DIV only).
  - Remainder sign = a_sign (REM only).
  - DIVU/REMU are unsigned.
- Divide by zero: DIV/DIVU result all-ones; REM/REMU result = op_a.
- Signed overflow: DIV result 0x80000000; REM result 0.
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN); no carries are exported.

Test Plan:
- MUL op_a=7, op_b=6, rd_i=5, start at cycle 0 -> stall high cycles 0–32; busy high cycles 1–33; done at cycle 33 with result=42 and rd_o=5; done low at cycle 34.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MUL 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF/2 -> 1. All complete at cycle 33.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. Each: done at cycle 1, stall high only in cycle 0.
- Start DIVU; kill at cycle 10 -> IDLE at cycle 11; no done; result keeps its previous value. New start at cycle 12 -> done at cycle 45.
- rst asserted at cycle 5 of a MUL -> at cycle 6 busy=0, done=0, result=0. Second start held high during CALC -> ignored; exactly one done.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with early completion for divide corner cases.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_i,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;
    logic [4:0]          rd_q;
    logic [4:0]          tag_q;
    logic [2:0]          op_q;
    logic                a_sign_q;
    logic                b_sign_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     divisor_q;

    function automatic logic [XLEN-1:0] neg_if(input logic s, input logic [XLEN-1:0] v);
        return s ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_final(input logic [2*XLEN-1:0] p,
                                                  input logic s, input logic lo);
        logic [2*XLEN-1:0] r;
        r = s ? (~p + 1'b1) : p;
        return lo ? r[XLEN-1:0] : r[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_final(input logic [XLEN-1:0] quo,
                                                  input logic [XLEN-1:0] rem,
                                                  input logic qs, input logic rs,
                                                  input logic is_rem);
        return is_rem ? neg_if(rs, rem) : neg_if(qs, quo);
    endfunction

    // Divide-by-zero and signed-overflow answers, available without iterating.
    function automatic logic [XLEN-1:0] special_res(input logic is_rem, input logic bz,
                                                    input logic [XLEN-1:0] a);
        if (bz)
            return is_rem ? a : {XLEN{1'b1}};
        return is_rem ? {XLEN{1'b0}} : MIN_NEG;
    endfunction

    logic            a_signed_op, b_signed_op;
    logic            a_sign_in, b_sign_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, sgn_ovf, special;

    always_comb begin
        a_signed_op = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_op = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_sign_in   = a_signed_op & op_a[XLEN-1];
        b_sign_in   = b_signed_op & op_b[XLEN-1];
        a_mag       = neg_if(a_sign_in, op_a);
        b_mag       = neg_if(b_sign_in, op_b);
        b_zero      = (op_b == '0);
        sgn_ovf     = (op_a == MIN_NEG) && (&op_b) && !funct3[0];
        special     = funct3[2] && (b_zero || sgn_ovf);
    end

    logic [2*XLEN-1:0] prod_d;
    logic [XLEN:0]     trial, diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_d, quo_d;

    always_comb begin
        prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        trial  = {rem_q, quo_q[XLEN-1]};
        diff   = trial - {1'b0, divisor_q};
        qbit   = ~diff[XLEN];
        rem_d  = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
        quo_d  = {quo_q[XLEN-2:0], qbit};
    end

    assign stall  = ~rst & (((state_q == IDLE) & start) | (state_q == CALC));
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_o   = rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
            tag_q     <= '0;
            op_q      <= '0;
            a_sign_q  <= 1'b0;
            b_sign_q  <= 1'b0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else if (kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (special) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res(funct3[1], b_zero, op_a);
                            rd_q     <= rd_i;
                        end else begin
                            state_q   <= CALC;
                            cnt_q     <= '0;
                            op_q      <= funct3;
                            tag_q     <= rd_i;
                            a_sign_q  <= a_sign_in;
                            b_sign_q  <= b_sign_in;
                            prod_q    <= '0;
                            mcand_q   <= {{XLEN{1'b0}}, a_mag};
                            mplier_q  <= b_mag;
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            divisor_q <= b_mag;
                        end
                    end
                end
                CALC: begin
                    cnt_q    <= cnt_q + 1'b1;
                    prod_q   <= prod_d;
                    mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
                    rem_q    <= rem_d;
                    quo_q    <= quo_d;
                    // The final iteration's values are folded straight into the result.
                    if (cnt_q == LAST_ITER) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        rd_q    <= tag_q;
                        result_q <= op_q[2]
                            ? div_final(quo_d, rem_d, a_sign_q ^ b_sign_q, a_sign_q, op_q[1])
                            : mul_final(prod_d, a_sign_q ^ b_sign_q, op_q[1:0] == 2'b00);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results with their due cycle,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_i;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_o;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_i(rd_i), .stall(stall), .busy(busy),
        .done(done), .result(result), .rd_o(rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit / 32-bit arithmetic from the RV32M definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb_, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ia  = a;
        ib  = b;
        case (f)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
        return f[2] && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && !f[0]));
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got result %h rd %0d, expected no done (cycle %0d)",
                             result, rd_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.res);
                    chk("rd_o", rd_o, mon_e.rd);
                    chk("done_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op with start high in the current cycle; optionally score it.
    task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input bit score);
        exp_t e;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_i   = rd;
        start  = 1'b1;
        if (score) begin
            e.res = ref_op(f, a, b);
            e.rd  = rd;
            e.at  = cyc + (is_early(f, a, b) ? 1 : 33);
            sb.push_back(e);
            last_res = e.res;
        end
    endtask

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit score);
        present(f, a, b, rd, score);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy %b after %0d cycles, expected 0", busy, n);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        kill   = 1'b0;
        funct3 = 3'd0;
        op_a   = 32'd3;
        op_b   = 32'd4;
        rd_i   = 5'd9;
        tick();
        tick();
        chk("rst_stall", stall, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_o", rd_o, 5'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        // MUL 7*6 with cycle-by-cycle control checks.
        present(3'd0, 32'd7, 32'd6, 5'd5, 1'b1);
        for (int k = 0; k <= 34; k++) begin
            #1;
            chk($sformatf("mul_stall_c%0d", k), stall, (k <= 32));
            chk($sformatf("mul_busy_c%0d", k), busy, (k >= 1 && k <= 33));
            chk($sformatf("mul_done_c%0d", k), done, (k == 33));
            tick();
            start = 1'b0;
        end

        launch(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1); wait_idle();
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1); wait_idle();
        launch(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1); wait_idle();
        launch(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1); wait_idle();
        launch(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1); wait_idle();
        launch(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1); wait_idle();
        launch(3'd5, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b1); wait_idle();
        launch(3'd7, 32'hFFFF_FFFF, 32'd2, 5'd9, 1'b1); wait_idle();

        // Early-completion cases: stall only in the start cycle, done one cycle later.
        present(3'd4, 32'd5, 32'd0, 5'd10, 1'b1);
        for (int k = 0; k <= 2; k++) begin
            #1;
            chk($sformatf("dz_stall_c%0d", k), stall, (k == 0));
            chk($sformatf("dz_done_c%0d", k), done, (k == 1));
            tick();
            start = 1'b0;
        end
        launch(3'd6, 32'd5, 32'd0, 5'd11, 1'b1); wait_idle();
        launch(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1); wait_idle();
        launch(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1); wait_idle();

        // Kill a DIVU at relative cycle 10, restart at 12.
        launch(3'd5, 32'd1000, 32'd7, 5'd14, 1'b0);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_busy", busy, 1'b0);
        chk("kill_done", done, 1'b0);
        chk("kill_result", result, last_res);
        chk("kill_stall", stall, 1'b0);
        tick();
        launch(3'd5, 32'd1000, 32'd7, 5'd15, 1'b1);
        wait_idle();

        // Reset in the middle of a MUL.
        launch(3'd0, 32'd123, 32'd456, 5'd16, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_result", result, 32'd0);
        rst = 1'b0;
        last_res = '0;
        tick();

        // start held through CALC and DONE must yield a single operation.
        present(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1'b1);
        repeat (34) tick();
        start = 1'b0;
        tick();
        chk("held_start_busy", busy, 1'b0);
        tick();

        for (int i = 0; i < 150; i++) begin
            launch(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 1'b1);
            wait_idle();
        end

        for (int n = 0; n < 100 && sb.size() > 0; n++) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
